// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with PSW flags, decimal adjust and iterative MUL/DIV.
// Define ALU_MC_DIV_EN to build the restoring divider; otherwise DIV is a single-cycle stub.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             c_in,
  input  logic             ac_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic             c_out,
  output logic             ac_out,
  output logic             ov_out,
  output logic [2:0]       flag_we
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'h00, OP_ADDC = 5'h01, OP_SUBB = 5'h02, OP_INC  = 5'h03,
                         OP_DEC  = 5'h04, OP_MUL  = 5'h05, OP_DIV  = 5'h06, OP_DA   = 5'h07,
                         OP_ANL  = 5'h08, OP_ORL  = 5'h09, OP_XRL  = 5'h0A, OP_CPL  = 5'h0B,
                         OP_SETB = 5'h0C, OP_CLR  = 5'h0D, OP_RL   = 5'h0E, OP_RR   = 5'h0F,
                         OP_RLC  = 5'h10, OP_RRC  = 5'h11, OP_SWAP = 5'h12;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] b_q, hi_q, lo_q, hi_d, lo_d;
  logic             ac_in_q;
  logic [WIDTH-1:0] ans_q, ans_hi_q;
  logic             c_q, ac_q, ov_q;
  logic [2:0]       we_q;
`ifdef ALU_MC_DIV_EN
  logic             is_div_q;
`endif

  logic             accept, iter_op, last_iter;
  logic [WIDTH-1:0] s_ans, s_hi;
  logic             s_cy, s_ac, s_ov;
  logic [2:0]       s_we;
  logic [WIDTH:0]   add_w, mul_sum;
  logic [8:0]       da_v1;
  logic [7:0]       da_v2;

  assign accept    = start && (state_q != S_ITER);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
`ifdef ALU_MC_DIV_EN
  assign iter_op   = (alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b_data != '0));
`else
  assign iter_op   = (alu_op == OP_MUL);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // DONE samples start exactly like IDLE so back-to-back operations lose no cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ITER:  if (last_iter) state_d = S_DONE;
      default: state_d = start ? (iter_op ? S_ITER : S_DONE) : S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_ITER);
    done = (state_q == S_DONE);
  end

  always_comb begin
    s_ans = '0;
    s_hi  = '0;
    s_cy  = c_in;
    s_ac  = ac_in;
    s_ov  = 1'b0;
    s_we  = 3'b000;
    add_w = '0;
    da_v1 = '0;
    da_v2 = '0;
    case (alu_op)
      OP_ADD, OP_ADDC: begin
        add_w = {1'b0, a_data} + {1'b0, b_data} + {{WIDTH{1'b0}}, (alu_op == OP_ADDC) & c_in};
        s_ans = add_w[M:0];
        s_cy  = add_w[WIDTH];
        s_ac  = a_data[4] ^ b_data[4] ^ add_w[4];
        s_ov  = (a_data[M] == b_data[M]) && (add_w[M] != a_data[M]);
        s_we  = 3'b111;
      end
      OP_SUBB: begin
        add_w = {1'b0, a_data} - {1'b0, b_data} - {{WIDTH{1'b0}}, c_in};
        s_ans = add_w[M:0];
        s_cy  = add_w[WIDTH];
        s_ac  = a_data[4] ^ b_data[4] ^ add_w[4];
        s_ov  = (a_data[M] != b_data[M]) && (add_w[M] != a_data[M]);
        s_we  = 3'b111;
      end
      OP_INC:  s_ans = a_data + WIDTH'(1);
      OP_DEC:  s_ans = a_data - WIDTH'(1);
      OP_DIV: begin
        // Reaches here only for B=0 or when the divider is not built.
        s_cy = 1'b0;
        s_ov = 1'b1;
        s_we = 3'b101;
`ifdef ALU_MC_DIV_EN
        s_hi = a_data;
`endif
      end
      OP_DA: begin
        da_v1 = {1'b0, a_data[7:0]};
        if ((a_data[3:0] > 4'd9) || ac_in) da_v1 = da_v1 + 9'h006;
        da_v2 = da_v1[7:0];
        if ((da_v1[7:4] > 4'd9) || c_in || da_v1[8]) begin
          da_v2 = da_v1[7:0] + 8'h60;
          s_cy  = 1'b1;
        end
        s_ans      = a_data;
        s_ans[7:0] = da_v2;
        s_we       = 3'b100;
      end
      OP_ANL:  s_ans = a_data & b_data;
      OP_ORL:  s_ans = a_data | b_data;
      OP_XRL:  s_ans = a_data ^ b_data;
      OP_CPL:  s_ans = ~a_data;
      OP_SETB: s_ans = WIDTH'(1);
      OP_CLR:  s_ans = '0;
      OP_RL:   s_ans = {a_data[M-1:0], a_data[M]};
      OP_RR:   s_ans = {a_data[0], a_data[M:1]};
      OP_RLC: begin
        s_ans = {a_data[M-1:0], c_in};
        s_cy  = a_data[M];
        s_we  = 3'b100;
      end
      OP_RRC: begin
        s_ans = {c_in, a_data[M:1]};
        s_cy  = a_data[0];
        s_we  = 3'b100;
      end
      OP_SWAP: s_ans = {a_data[WIDTH/2-1:0], a_data[M:WIDTH/2]};
      default: begin
        s_cy = 1'b0;
        s_ac = 1'b0;
      end
    endcase
  end

  // One iteration step: {hi,lo} is the product shift register or the remainder/quotient pair.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    hi_d    = mul_sum[WIDTH:1];
    lo_d    = {mul_sum[0], lo_q[M:1]};
`ifdef ALU_MC_DIV_EN
    if (is_div_q) begin
      if ({hi_q, lo_q[M]} >= {1'b0, b_q}) begin
        hi_d = {hi_q[M-1:0], lo_q[M]} - b_q;
        lo_d = {lo_q[M-1:0], 1'b1};
      end else begin
        hi_d = {hi_q[M-1:0], lo_q[M]};
        lo_d = {lo_q[M-1:0], 1'b0};
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ac_in_q  <= 1'b0;
      ans_q    <= '0;
      ans_hi_q <= '0;
      c_q      <= 1'b0;
      ac_q     <= 1'b0;
      ov_q     <= 1'b0;
      we_q     <= 3'b000;
`ifdef ALU_MC_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q   <= '0;
      b_q     <= b_data;
      hi_q    <= '0;
      lo_q    <= a_data;
      ac_in_q <= ac_in;
`ifdef ALU_MC_DIV_EN
      is_div_q <= (alu_op == OP_DIV);
`endif
      if (!iter_op) begin
        ans_q    <= s_ans;
        ans_hi_q <= s_hi;
        c_q      <= s_cy;
        ac_q     <= s_ac;
        ov_q     <= s_ov;
        we_q     <= s_we;
      end
    end else if (state_q == S_ITER) begin
      cnt_q <= cnt_q + CW'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      if (last_iter) begin
        ans_q    <= lo_d;
        ans_hi_q <= hi_d;
        c_q      <= 1'b0;
        ac_q     <= ac_in_q;
`ifdef ALU_MC_DIV_EN
        ov_q     <= !is_div_q && (hi_d != '0);
`else
        ov_q     <= (hi_d != '0);
`endif
        we_q     <= 3'b101;
      end
    end
  end

  assign ans     = ans_q;
  assign ans_hi  = ans_hi_q;
  assign c_out   = c_q;
  assign ac_out  = ac_q;
  assign ov_out  = ov_q;
  assign flag_we = we_q;

endmodule
